// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller sharing one full-adder slice over WIDTH cycles
// Ports: clk, rst (synchronous, active-high)
//        start_i, op_a_i, op_b_i : request; operands are captured when start is accepted in IDLE
//        busy_o, done_o          : status; done_o pulses for one cycle when the result is valid
//        sum_o, cout_o           : registered result, held until the next done or reset
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q, rs_q, rs_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, carry_d, hs, s_d;
    // Two half adders plus an OR form the shared full-adder slice.
    assign hs      = sa_q[0] ^ sb_q[0];
    assign s_d     = hs ^ carry_q;
    assign carry_d = (sa_q[0] & sb_q[0]) | (hs & carry_q);
    // Each new sum bit enters at the MSB, so bit i ends up in rs[i] after WIDTH shifts.
    if (WIDTH == 1) begin : g_rs1
        assign rs_d = s_d;
    end else begin : g_rsn
        assign rs_d = {s_d, rs_q[WIDTH-1:1]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            rs_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            sum_o   <= '0;
            cout_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        sa_q    <= op_a_i;
                        sb_q    <= op_b_i;
                        rs_q    <= '0;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy_o  <= 1'b1;
                    end
                end
                RUN: begin
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    carry_q <= carry_d;
                    rs_q    <= rs_d;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        // Counter wraps to 0 here so it never exceeds WIDTH-1.
                        cnt_q   <= '0;
                        sum_o   <= rs_d;
                        cout_o  <= carry_d;
                        state_q <= DONE;
                        done_o  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1 with a timeline model
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s8, s1, busy8, done8, cout8, busy1, done1, cout1;
    logic [7:0] a8, b8, sum8;
    logic [0:0] a1, b1, sum1;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         armed = 1'b0;
    int         wid[2] = '{8, 1};
    bit         act[2];
    bit         ed[2];
    int         t0[2], res[2], es[2], ec[2];
    int         cyc = 0;
    int         q8[$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start_i(s8), .op_a_i(a8), .op_b_i(b8),
        .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
    );
    serial_add_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start_i(s1), .op_a_i(a1), .op_b_i(b1),
        .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, got, exp, $time);
        end
    endtask

    // Timeline model: an accepted start at edge t yields the result at edge t+W
    // and the controller is free again after edge t+W+1.
    always @(posedge clk) begin
        cyc++;
        for (int n = 0; n < 2; n++) begin
            if (rst) begin
                act[n] = 1'b0;
                ed[n]  = 1'b0;
                es[n]  = 0;
                ec[n]  = 0;
            end else begin
                ed[n] = 1'b0;
                if (act[n]) begin
                    if (cyc - t0[n] == wid[n]) begin
                        es[n] = res[n] % (1 << wid[n]);
                        ec[n] = res[n] >> wid[n];
                        ed[n] = 1'b1;
                    end else if (cyc - t0[n] == wid[n] + 1) begin
                        act[n] = 1'b0;
                    end
                end else if (n == 0 ? s8 : s1) begin
                    act[n] = 1'b1;
                    t0[n]  = cyc;
                    res[n] = (n == 0) ? int'(a8) + int'(b8) : int'(a1) + int'(b1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("busy8", busy8, act[0]);
            check("done8", done8, ed[0]);
            check("sum8", sum8, es[0]);
            check("cout8", cout8, ec[0]);
            check("busy1", busy1, act[1]);
            check("done1", done1, ed[1]);
            check("sum1", sum1, es[1]);
            check("cout1", cout1, ec[1]);
            if (done8 === 1'b1) q8.push_back(int'({cout8, sum8}));
        end
    end

    task automatic go8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        a8 = a;
        b8 = b;
        s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
    endtask

    task automatic go1(input logic a, input logic b);
        @(negedge clk);
        a1 = a;
        b1 = b;
        s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
    endtask

    initial begin
        s8 = 1'b0; s1 = 1'b0; a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        armed = 1'b1;
        check("reset_busy", busy8, 0);
        check("reset_sum", sum8, 0);
        // 0x3C + 0x0F
        go8(8'h3C, 8'h0F);
        repeat (7) @(negedge clk);
        check("t1_no_early_done", done8, 0);
        @(negedge clk);
        check("t1_done", done8, 1);
        check("t1_sum", sum8, 8'h4B);
        check("t1_cout", cout8, 0);
        check("t1_model_sum", es[0], 8'h4B);
        @(negedge clk);
        check("t1_busy_fall", busy8, 0);
        // 0xFF + 0x01 then 0xFF + 0xFF with hold of the first result
        go8(8'hFF, 8'h01);
        repeat (8) @(negedge clk);
        check("t2a_sum", sum8, 8'h00);
        check("t2a_cout", cout8, 1);
        @(negedge clk);
        go8(8'hFF, 8'hFF);
        repeat (4) @(negedge clk);
        check("t2_hold_sum", sum8, 8'h00);
        check("t2_hold_cout", cout8, 1);
        repeat (4) @(negedge clk);
        check("t2b_sum", sum8, 8'hFE);
        check("t2b_cout", cout8, 1);
        check("t2b_model", es[0], 8'hFE);
        // start held high, op_b changed mid-run
        repeat (2) @(negedge clk);
        q8.delete();
        a8 = 8'h01; b8 = 8'h02; s8 = 1'b1;
        repeat (4) @(negedge clk);
        b8 = 8'h05;
        repeat (21) @(negedge clk);
        s8 = 1'b0;
        repeat (12) @(negedge clk);
        check("t3_count", q8.size(), 3);
        check("t3_first", q8[0], 32'h003);
        check("t3_second", q8[1], 32'h006);
        check("t3_third", q8[2], 32'h006);
        // start pulsed during RUN and DONE is ignored
        q8.delete();
        go8(8'h10, 8'h20);
        repeat (2) @(negedge clk);
        a8 = 8'h77; b8 = 8'h11; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_done", done8, 1);
        a8 = 8'h55; b8 = 8'h66; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (12) @(negedge clk);
        check("t4_count", q8.size(), 1);
        check("t4_result", q8[0], 32'h030);
        check("t4_sum", sum8, 8'h30);
        // reset in the middle of 0xAA + 0x55
        go8(8'hAA, 8'h55);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", busy8, 0);
        check("t5_done", done8, 0);
        check("t5_sum", sum8, 0);
        check("t5_cout", cout8, 0);
        q8.delete();
        repeat (12) @(negedge clk);
        check("t5_no_done", q8.size(), 0);
        go8(8'h12, 8'h34);
        repeat (9) @(negedge clk);
        check("t5_after_sum", sum8, 8'h46);
        check("t5_after_cout", cout8, 0);
        // WIDTH=1
        go1(1'b1, 1'b1);
        check("t6a_running", done1, 0);
        @(negedge clk);
        check("t6a_done", done1, 1);
        check("t6a_sum", sum1, 0);
        check("t6a_cout", cout1, 1);
        repeat (2) @(negedge clk);
        go1(1'b0, 1'b1);
        @(negedge clk);
        check("t6b_done", done1, 1);
        check("t6b_sum", sum1, 1);
        check("t6b_cout", cout1, 0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
